host_burst_arb: RTL and testbench

Round-robin burst arbiter that shares the single host SPI readout path between the on-chip data sources (GPS sample buffer, receiver audio/IQ, waterfall). It grants one source at a time for a length-specified burst and pops that source's show-ahead output with one-hot read strobes. It forwards each word to the host interface with start/end-of-burst framing. It sits in the cpu_clk domain between the source FIFOs and the HOST SPI block, and stops a burst if the host stalls past a timeout.

---
 rtl/host_burst_arb_if.sv | 29 ++
 rtl/host_burst_arb.sv | 119 +++++++++++
 tb/tb_host_burst_arb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/host_burst_arb_if.sv
// host_burst_arb_if: source, grant and host-side signals of the burst arbiter
interface host_burst_arb_if #(
  parameter int NREQ = 3,
  parameter int DW = 16,
  parameter int LENW = 12
);
  logic [NREQ-1:0] req;
  logic [NREQ*LENW-1:0] len;
  logic [NREQ*DW-1:0] src_dout;
  logic [NREQ-1:0] src_rd;
  logic [NREQ-1:0] gnt;
  logic busy;
  logic host_ready;
  logic [DW-1:0] host_dout;
  logic host_valid;
  logic host_sof;
  logic host_eof;
  logic abort;
  logic err_clr;
  logic err_tmo;
  modport slave (
    input req, len, src_dout, host_ready, abort, err_clr,
    output src_rd, gnt, busy, host_dout, host_valid, host_sof, host_eof, err_tmo
  );
  modport master (
    output req, len, src_dout, host_ready, abort, err_clr,
    input src_rd, gnt, busy, host_dout, host_valid, host_sof, host_eof, err_tmo
  );
endinterface

// File: rtl/host_burst_arb.sv
// host_burst_arb: round-robin burst arbiter feeding the host SPI readout path
module host_burst_arb #(
  parameter int NREQ = 3,
  parameter int DW = 16,
  parameter int LENW = 12,
  parameter int TMO = 255
) (
  input logic clk,
  input logic rst_n,
  host_burst_arb_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(TMO + 1);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, win, cand;
  logic found, pop, busy;
  logic [LENW-1:0] rem_q, rem_d;
  logic [SW-1:0] stall_q, stall_d;
  logic first_q, first_d, err_q, err_d, vld_q, vld_d, sof_q, sof_d, eof_q, eof_d;
  logic [DW-1:0] dout_q, dout_d;
  logic [NREQ-1:0] gnt;
  logic [LENW-1:0] len_a [NREQ];
  logic [DW-1:0] dat_a [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign len_a[i] = bus.len[i*LENW +: LENW];
    assign dat_a[i] = bus.src_dout[i*DW +: DW];
  end
  always_comb begin
    win = '0;
    cand = '0;
    found = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = IW'((32'(ptr_q) + 32'(i)) % NREQ);
      if (bus.req[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  assign busy = state_q == XFER;
  assign gnt = busy ? NREQ'(1) << idx_q : '0;
  assign pop = busy && bus.host_ready && rem_q != '0 && !bus.abort;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    rem_d = rem_q;
    stall_d = stall_q;
    first_d = first_q;
    err_d = err_q & ~bus.err_clr;
    vld_d = pop;
    sof_d = pop & first_q;
    eof_d = pop & (rem_q == LENW'(1));
    dout_d = pop ? dat_a[idx_q] : dout_q;
    if (bus.abort) begin
      state_d = IDLE;
      rem_d = '0;
    end else if (state_q == IDLE) begin
      if (found) begin
        state_d = XFER;
        idx_d = win;
        rem_d = len_a[win];
        first_d = 1'b1;
        stall_d = '0;
      end
    end else if (rem_q == '0) begin
      state_d = IDLE;
      ptr_d = idx_q;
    end else if (pop) begin
      first_d = 1'b0;
      rem_d = rem_q - 1'b1;
      stall_d = '0;
      state_d = rem_q == LENW'(1) ? IDLE : XFER;
      ptr_d = rem_q == LENW'(1) ? idx_q : ptr_q;
    end else if (stall_q == SW'(TMO - 1)) begin
      err_d = 1'b1;
      state_d = IDLE;
      ptr_d = idx_q;
    end else begin
      stall_d = stall_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      idx_q <= '0;
      rem_q <= '0;
      stall_q <= '0;
      first_q <= 1'b0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
      sof_q <= 1'b0;
      eof_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      stall_q <= stall_d;
      first_q <= first_d;
      err_q <= err_d;
      vld_q <= vld_d;
      sof_q <= sof_d;
      eof_q <= eof_d;
      dout_q <= dout_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.busy = busy;
  assign bus.src_rd = pop ? gnt : '0;
  assign bus.host_dout = dout_q;
  assign bus.host_valid = vld_q;
  assign bus.host_sof = sof_q;
  assign bus.host_eof = eof_q;
  assign bus.err_tmo = err_q;
endmodule

// File: tb/tb_host_burst_arb.sv
// tb_host_burst_arb: directed and randomized bench against a behavioural burst model
module tb_host_burst_arb;
  localparam int NREQ = 3;
  localparam int DW = 16;
  localparam int LENW = 12;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  host_burst_arb_if #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) bus ();
  host_burst_arb #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .TMO(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_owner, m_left, m_stalls, m_ptr;
  bit m_first, m_err, e_valid, e_sof, e_eof;
  logic [DW-1:0] e_dout;
  int m_cnt [NREQ];
  int cnt [NREQ];
  logic [NREQ-1:0] rd_s;
  logic [NREQ-1:0] s_req;
  int s_len [NREQ];
  bit s_ready, s_abort, s_clr;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] word(int i, int n);
    return DW'((i << 12) | (n & 'hFFF));
  endfunction
  function automatic logic [NREQ-1:0] onehot(int o);
    return o < 0 ? '0 : NREQ'(1) << o;
  endfunction
  task automatic model_reset();
    m_owner = -1;
    m_left = 0;
    m_stalls = 0;
    m_ptr = NREQ - 1;
    m_first = 0;
    m_err = 0;
    e_valid = 0;
    e_sof = 0;
    e_eof = 0;
    e_dout = '0;
  endtask
  task automatic model_step();
    e_valid = 0;
    e_sof = 0;
    e_eof = 0;
    if (s_clr) m_err = 0;
    if (s_abort) begin
      m_owner = -1;
      m_left = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c = (m_ptr + k) % NREQ;
        if (s_req[c] && m_owner < 0) begin
          m_owner = c;
          m_left = s_len[c];
          m_first = 1;
          m_stalls = 0;
        end
      end
    end else if (m_left == 0) begin
      m_ptr = m_owner;
      m_owner = -1;
    end else if (s_ready) begin
      e_valid = 1;
      e_sof = m_first;
      e_eof = m_left == 1;
      e_dout = word(m_owner, m_cnt[m_owner]);
      m_cnt[m_owner]++;
      m_first = 0;
      m_left--;
      m_stalls = 0;
      if (m_left == 0) begin
        m_ptr = m_owner;
        m_owner = -1;
      end
    end else begin
      m_stalls++;
      if (m_stalls == TMO) begin
        m_err = 1;
        m_ptr = m_owner;
        m_owner = -1;
      end
    end
  endtask
  task automatic cyc();
    logic [NREQ-1:0] e_rd;
    bus.req = s_req;
    for (int i = 0; i < NREQ; i++) bus.len[i*LENW +: LENW] = LENW'(s_len[i]);
    bus.host_ready = s_ready;
    bus.abort = s_abort;
    bus.err_clr = s_clr;
    #1;
    e_rd = (m_owner >= 0 && s_ready && m_left > 0 && !s_abort) ? onehot(m_owner) : '0;
    rd_s = bus.src_rd;
    chk("src_rd", 64'(rd_s), 64'(e_rd));
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_s[i]) cnt[i]++;
      bus.src_dout[i*DW +: DW] = word(i, cnt[i]);
    end
    chk("gnt", 64'(bus.gnt), 64'(onehot(m_owner)));
    chk("busy", 64'(bus.busy), 64'(m_owner >= 0));
    chk("host_valid", 64'(bus.host_valid), 64'(e_valid));
    chk("host_sof", 64'(bus.host_sof), 64'(e_sof));
    chk("host_eof", 64'(bus.host_eof), 64'(e_eof));
    chk("err_tmo", 64'(bus.err_tmo), 64'(m_err));
    if (e_valid) chk("host_dout", 64'(bus.host_dout), 64'(e_dout));
  endtask
  initial begin
    logic [NREQ-1:0] seen [$];
    logic [NREQ-1:0] prev;
    int rd1, pct;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i] = 0;
      m_cnt[i] = 0;
      s_len[i] = 0;
      bus.src_dout[i*DW +: DW] = word(i, 0);
    end
    s_req = '0;
    s_ready = 0;
    s_abort = 0;
    s_clr = 0;
    bus.req = '0;
    bus.len = '0;
    bus.host_ready = 1'b0;
    bus.abort = 1'b0;
    bus.err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.host_valid), 64'd0);
    chk("rst_dout", 64'(bus.host_dout), 64'd0);
    chk("rst_err", 64'(bus.err_tmo), 64'd0);
    chk("rst_rd", 64'(bus.src_rd), 64'd0);
    rst_n = 1'b1;
    s_req = 3'b111;
    s_len[0] = 2;
    s_len[1] = 2;
    s_len[2] = 2;
    s_ready = 1;
    prev = '0;
    repeat (12) begin
      cyc();
      if (bus.gnt != '0 && prev == '0) seen.push_back(bus.gnt);
      prev = bus.gnt;
    end
    chk("rr_count", 64'(seen.size()), 64'd4);
    chk("rr_0", 64'(seen.size() > 0 ? seen[0] : 3'b000), 64'b001);
    chk("rr_1", 64'(seen.size() > 1 ? seen[1] : 3'b000), 64'b010);
    chk("rr_2", 64'(seen.size() > 2 ? seen[2] : 3'b000), 64'b100);
    chk("rr_3", 64'(seen.size() > 3 ? seen[3] : 3'b000), 64'b001);
    s_req = '0;
    cyc();
    s_req = 3'b010;
    s_len[1] = 4;
    cyc();
    chk("single_gnt", 64'(bus.gnt), 64'b010);
    chk("single_busy", 64'(bus.busy), 64'd1);
    s_req = '0;
    rd1 = 0;
    for (int j = 0; j < 4; j++) begin
      cyc();
      rd1 += int'(rd_s[1]);
      chk("single_valid", 64'(bus.host_valid), 64'd1);
      chk("single_sof", 64'(bus.host_sof), 64'(j == 0));
      chk("single_eof", 64'(bus.host_eof), 64'(j == 3));
    end
    chk("single_rd_count", 64'(rd1), 64'd4);
    chk("single_busy_end", 64'(bus.busy), 64'd0);
    cyc();
    chk("single_valid_end", 64'(bus.host_valid), 64'd0);
    s_req = 3'b101;
    s_len[0] = 1;
    s_len[2] = 0;
    cyc();
    chk("zero_gnt", 64'(bus.gnt), 64'b100);
    cyc();
    chk("zero_rd", 64'(rd_s), 64'd0);
    chk("zero_valid", 64'(bus.host_valid), 64'd0);
    chk("zero_gnt_clr", 64'(bus.gnt), 64'd0);
    cyc();
    chk("zero_next_gnt", 64'(bus.gnt), 64'b001);
    s_req = '0;
    cyc();
    cyc();
    s_req = 3'b010;
    s_len[1] = 5;
    s_ready = 1;
    cyc();
    s_req = '0;
    cyc();
    cyc();
    s_ready = 0;
    repeat (7) cyc();
    chk("tmo_err_before", 64'(bus.err_tmo), 64'd0);
    chk("tmo_busy_before", 64'(bus.busy), 64'd1);
    cyc();
    chk("tmo_err", 64'(bus.err_tmo), 64'd1);
    chk("tmo_gnt", 64'(bus.gnt), 64'd0);
    chk("tmo_eof", 64'(bus.host_eof), 64'd0);
    s_clr = 1;
    cyc();
    chk("tmo_clr", 64'(bus.err_tmo), 64'd0);
    s_clr = 0;
    s_req = 3'b010;
    s_len[1] = 3;
    cyc();
    s_req = '0;
    repeat (7) cyc();
    s_clr = 1;
    cyc();
    chk("tmo_set_wins", 64'(bus.err_tmo), 64'd1);
    cyc();
    chk("tmo_clr2", 64'(bus.err_tmo), 64'd0);
    s_clr = 0;
    s_req = 3'b011;
    s_len[0] = 10;
    s_len[1] = 10;
    s_ready = 1;
    cyc();
    chk("abort_gnt", 64'(bus.gnt), 64'b001);
    cyc();
    cyc();
    s_abort = 1;
    cyc();
    chk("abort_rd", 64'(rd_s), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.host_valid), 64'd0);
    s_abort = 0;
    cyc();
    chk("abort_ptr", 64'(bus.gnt), 64'b001);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 64'(bus.gnt), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_valid", 64'(bus.host_valid), 64'd0);
    chk("arst_sof", 64'(bus.host_sof), 64'd0);
    chk("arst_eof", 64'(bus.host_eof), 64'd0);
    chk("arst_dout", 64'(bus.host_dout), 64'd0);
    chk("arst_rd", 64'(bus.src_rd), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      pct = (n / 500) % 4 == 0 ? 90 : (n / 500) % 4 == 1 ? 50 : (n / 500) % 4 == 2 ? 10 : 100;
      s_req = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++)
        s_len[i] = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
      s_ready = $urandom_range(0, 99) < pct;
      s_abort = $urandom_range(0, 63) == 0;
      s_clr = $urandom_range(0, 31) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
